pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Multi-channel duty-cycle scheduler that feeds the `duty` inputs of NUM_CH pwm instances. It accepts per-channel target/step commands over a valid/ready handshake. On each update tick it slews every channel's duty toward its target using a single shared adder/comparator, one channel per clock. It is used for soft-start of motors and servos so that duty never jumps by more than `step` per PWM period.

Parameters:
CLK_FREQ, 25000000, frequency of clk in Hz
UPDATE_HZ, 60, ramp update rate in Hz (one update per PWM period)
NUM_CH, 4, number of controlled PWM channels (1..16)
DUTY_W, 16, duty width; must equal $clog2(CLK_TICKS) of the driven pwm instances

Ports:
clk  input  1  system clock at CLK_FREQ
rst  input  1  synchronous reset, active high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at posedge
cmd_ch  input  $clog2(NUM_CH) (min 1)  target channel index
cmd_target  input  DUTY_W  new target duty
cmd_step  input  DUTY_W  max duty change per tick; 0 = jump immediately
cmd_err  output  1  one-cycle pulse: accepted command had cmd_ch >= NUM_CH
duty  output  NUM_CH*DUTY_W  current duties; channel i in bits [i*DUTY_W +: DUTY_W]
at_target  output  NUM_CH  bit i high when duty[i] == target[i]
done  output  NUM_CH  one-cycle pulse on bit i when channel i reaches its target during a scan

Behaviour:
- TICK_DIV = CLK_FREQ/UPDATE_HZ. Free-running divider counts 0..TICK_DIV-1. tick is high for 1 cycle when the count wraps to 0.
- Elaboration check: TICK_DIV must be > NUM_CH+1. Otherwise $error.
- FSM states: IDLE, SCAN.
- IDLE:
  - cmd_ready=1.
  - Handshake writes target[cmd_ch] and step[cmd_ch] at the posedge.
  - If step==0, duty[cmd_ch] also becomes target in the same write, so at_target is visible next cycle and done is not pulsed.
  - Invalid cmd_ch: command is consumed with no state change, and cmd_err pulses the next cycle.
  - tick moves the FSM to SCAN with idx=0. A tick and a handshake in the same cycle are both honoured: the scan sees the new target.
- SCAN:
  - cmd_ready=0.
  - Each cycle processes channel idx, then idx+1. After idx==NUM_CH-1, the FSM returns to IDLE. A scan lasts exactly NUM_CH cycles.
- Update rule, computed in DUTY_W+1 bits so there is no overflow or wrap:
  - d<t: d' = (t-d > s) ? d+s : t
  - d>t: d' = (d-t > s) ? d-s : t
  - d==t: no change
  - Step 0 in SCAN means jump: d' = t.
- done[idx] pulses for 1 cycle, the cycle after the update, iff d!=t before the update and d'==t after it.
- at_target is combinational from the registers.
- Boundaries:
  - Target 0xFFFF with step 0x8000 from 0: 0x8000, then 0xFFFF (saturate, no wrap).
  - A command to a channel mid-ramp overrides its target and step. The ramp continues from the current duty.
- Reset: duty=0, target=0, step=0, divider=0, FSM=IDLE, cmd_ready=0 while rst is high, cmd_err=0, done=0, at_target=all ones.
  - Reset mid-SCAN aborts the scan; all state is cleared as above.
  - cmd_ready=1 on the first cycle after rst deasserts.

Optional Feature:
PWM_RAMP_ESTOP_EN:
- Defined: adds input port `estop` (1 bit).
- While estop=1:
  - cmd_ready=0 and the FSM is held in IDLE, aborting any SCAN.
  - On each posedge, all duty and target registers are cleared to 0.
  - Ticks are ignored and done is held 0.
  - Normal operation resumes the cycle after estop falls.
- Not defined: no estop port and no related logic.

Test Plan:
- Reset release: rst high for 3 cycles, then low -> duty=0, at_target=all 1, done=0, cmd_ready=0 during reset and 1 on the first cycle after.
- Basic ramp (CLK_FREQ=1000, UPDATE_HZ=100, TICK_DIV=10): ch1 target=100 step=30 -> duty[1] goes 30, 60, 90, 100 on successive scans. done[1] pulses once, after the 4th scan. at_target[1]=1 afterwards.
- Downward ramp and jump: ch0 at 100, command target=10 step=40 -> 60, 20, 10. Then command target=500 step=0 -> duty[0]=500 the next cycle, no done pulse.
- Saturation: DUTY_W=16, target=0xFFFF, step=0x8000 from 0 -> 0x8000, then 0xFFFF. Never wraps to a small value.
- Handshake and collision: hold cmd_valid across a tick -> cmd_ready=0 for exactly NUM_CH cycles. The command is accepted on the first IDLE cycle, and the tick+handshake same cycle uses the new target. cmd_ch=5 with NUM_CH=4 -> cmd_err pulse, all duties unchanged.
- Reset mid-scan and estop (with PWM_RAMP_ESTOP_EN): assert rst during SCAN idx=2 -> all duties 0, FSM IDLE. estop=1 during a ramp -> duties 0 the next cycle, cmd_ready=0. Release estop -> cmd_ready=1.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Multi-channel duty slew scheduler for soft-starting PWM loads. Commands set a
// per-channel target and step. Once per update tick a scan walks every channel,
// one per clock, and moves its duty toward the target by at most one step.
// All channels share a single add/subtract/compare datapath.
//
// Optional build macro: PWM_RAMP_ESTOP_EN adds the 'estop' input. While high it
// clears all duties and targets, blocks commands, ignores ticks and holds done
// low.
//
// Ports:
//   clk         system clock (CLK_FREQ Hz)
//   rst         synchronous reset, active high
//   estop       emergency stop, active high (PWM_RAMP_ESTOP_EN builds only)
//   cmd_valid   command present
//   cmd_ready   command accepted when cmd_valid && cmd_ready at posedge
//   cmd_ch      channel index of the command
//   cmd_target  new target duty
//   cmd_step    max duty change per tick, 0 = jump immediately
//   cmd_err     one-cycle pulse after an accepted command with cmd_ch >= NUM_CH
//   duty        packed duties, channel i at [i*DUTY_W +: DUTY_W]
//   at_target   bit i high while duty i equals target i
//   done        one-cycle pulse on bit i when a scan brings channel i to target
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl #(
    parameter int unsigned CLK_FREQ  = 25000000,
    parameter int unsigned UPDATE_HZ = 60,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DUTY_W    = 16,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef PWM_RAMP_ESTOP_EN
    input  logic                     estop,
`endif
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CH_W-1:0]          cmd_ch,
    input  logic [DUTY_W-1:0]        cmd_target,
    input  logic [DUTY_W-1:0]        cmd_step,
    output logic                     cmd_err,
    output logic [NUM_CH*DUTY_W-1:0] duty,
    output logic [NUM_CH-1:0]        at_target,
    output logic [NUM_CH-1:0]        done
);

    localparam int unsigned TICK_DIV = CLK_FREQ / UPDATE_HZ;
    localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // A full scan plus one idle slot must fit inside one tick period.
    generate
        if (TICK_DIV <= NUM_CH + 1) begin : g_bad_tick_div
            $error("pwm_ramp_ctrl: TICK_DIV (%0d) must exceed NUM_CH+1 (%0d)",
                   TICK_DIV, NUM_CH + 1);
        end
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("pwm_ramp_ctrl: NUM_CH (%0d) must be 1..16", NUM_CH);
        end
    endgenerate

    // Emergency stop qualifier; tied low when the feature is not built.
    logic halt;
`ifdef PWM_RAMP_ESTOP_EN
    assign halt = estop;
`else
    assign halt = 1'b0;
`endif

    // Per-channel state
    logic [DUTY_W-1:0] duty_q   [NUM_CH];
    logic [DUTY_W-1:0] target_q [NUM_CH];
    logic [DUTY_W-1:0] step_q   [NUM_CH];

    // Control state
    logic [0:0]       state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic             scan_en;
    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic [NUM_CH-1:0] done_q;
    logic             cmd_err_q;

    // Command path
    logic cmd_fire;
    logic cmd_ok;

    // Shared slew datapath
    logic [DUTY_W-1:0] cur_d, cur_t, cur_s;
    logic              go_up;
    logic [DUTY_W:0]   gap;
    logic [DUTY_W:0]   moved;
    logic [DUTY_W-1:0] nxt_d;
    logic              reach;

    // Ready only in IDLE and never while reset or estop is asserted.
    assign cmd_ready = (state_q == ST_IDLE) && !rst && !halt;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_ok    = 32'(cmd_ch) < NUM_CH;

    // Update tick divider: tick_q is high for the cycle in which the count is 0
    // after a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (div_q == DIV_W'(TICK_DIV - 1)) begin
            div_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q + DIV_W'(1);
            tick_q <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: a tick in IDLE starts a scan over channels 0..NUM_CH-1.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        scan_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_q) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                scan_en = 1'b1;
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        if (halt) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            scan_en = 1'b0;
        end
    end

    // Slew one channel toward its target. The gap and the stepped value are
    // formed one bit wider so the comparison can never be fooled by a wrap; the
    // stepped value is only used when the gap exceeds the step, so it always
    // stays strictly between duty and target.
    always_comb begin
        cur_d = duty_q[idx_q];
        cur_t = target_q[idx_q];
        cur_s = step_q[idx_q];
        go_up = cur_d < cur_t;
        gap   = go_up ? ({1'b0, cur_t} - {1'b0, cur_d})
                      : ({1'b0, cur_d} - {1'b0, cur_t});
        moved = go_up ? ({1'b0, cur_d} + {1'b0, cur_s})
                      : ({1'b0, cur_d} - {1'b0, cur_s});
        nxt_d = cur_t;
        if (cur_s != '0 && gap > {1'b0, cur_s}) begin
            nxt_d = moved[DUTY_W-1:0];
        end
        reach = (cur_d != cur_t) && (nxt_d == cur_t);
    end

    // Channel registers, command writes and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_q[i]   <= '0;
                target_q[i] <= '0;
                step_q[i]   <= '0;
            end
            done_q    <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            done_q    <= '0;
            cmd_err_q <= 1'b0;

            // Commands land only in IDLE, scans only run in SCAN: no overlap.
            if (cmd_fire) begin
                if (cmd_ok) begin
                    target_q[cmd_ch] <= cmd_target;
                    step_q[cmd_ch]   <= cmd_step;
                    if (cmd_step == '0) begin
                        duty_q[cmd_ch] <= cmd_target;
                    end
                end else begin
                    cmd_err_q <= 1'b1;
                end
            end

            if (scan_en) begin
                duty_q[idx_q] <= nxt_d;
                done_q[idx_q] <= reach;
            end

            if (halt) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    duty_q[i]   <= '0;
                    target_q[i] <= '0;
                end
                done_q <= '0;
            end
        end
    end

    // Output packing
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_out
            assign duty[g*DUTY_W +: DUTY_W] = duty_q[g];
            assign at_target[g]             = (duty_q[g] == target_q[g]);
        end
    endgenerate

    assign done    = done_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
// Self-checking bench for pwm_ramp_ctrl. TICK_DIV = 1000/100 = 10. NUM_CH = 5
// makes cmd_ch three bits wide so that cmd_ch=5 is a representable, invalid
// index. One tick period is 5 scan cycles followed by 5 idle cycles, the last
// idle cycle carrying the tick.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

    localparam int unsigned CLK_FREQ  = 1000;
    localparam int unsigned UPDATE_HZ = 100;
    localparam int unsigned NUM_CH    = 5;
    localparam int unsigned DUTY_W    = 16;
    localparam int unsigned CH_W      = 3;
    localparam int unsigned BOUND     = 60;

    logic                     clk;
    logic                     rst;
`ifdef PWM_RAMP_ESTOP_EN
    logic                     estop;
`endif
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [CH_W-1:0]          cmd_ch;
    logic [DUTY_W-1:0]        cmd_target;
    logic [DUTY_W-1:0]        cmd_step;
    logic                     cmd_err;
    logic [NUM_CH*DUTY_W-1:0] duty;
    logic [NUM_CH-1:0]        at_target;
    logic [NUM_CH-1:0]        done;

    pwm_ramp_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .UPDATE_HZ(UPDATE_HZ),
        .NUM_CH   (NUM_CH),
        .DUTY_W   (DUTY_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PWM_RAMP_ESTOP_EN
        .estop     (estop),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_target(cmd_target),
        .cmd_step  (cmd_step),
        .cmd_err   (cmd_err),
        .duty      (duty),
        .at_target (at_target),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One ramp vector: command plus the duty expected after each scan.
    typedef struct packed {
        logic [CH_W-1:0]         ch;
        logic [DUTY_W-1:0]       target;
        logic [DUTY_W-1:0]       step;
        logic [2:0]              nscan;
        logic [3:0][DUTY_W-1:0]  exp;
        logic [1:0]              ndone;
    } vec_t;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DUTY_W-1:0] duty;
    } sb_t;

    int unsigned       test_cnt = 0;
    int unsigned       fail_cnt = 0;
    int unsigned       done_cnt [NUM_CH] = '{default: 0};
    logic [DUTY_W-1:0] m_duty   [NUM_CH];
    sb_t               sb_q [$];
    vec_t              vecs [8];

    // Count done pulses per channel, sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int unsigned ch, input int unsigned t, input int unsigned s,
                                input int unsigned n, input int unsigned e0, input int unsigned e1,
                                input int unsigned e2, input int unsigned e3, input int unsigned nd);
        vec_t v;
        v.ch     = CH_W'(ch);
        v.target = DUTY_W'(t);
        v.step   = DUTY_W'(s);
        v.nscan  = 3'(n);
        v.exp[0] = DUTY_W'(e0);
        v.exp[1] = DUTY_W'(e1);
        v.exp[2] = DUTY_W'(e2);
        v.exp[3] = DUTY_W'(e3);
        v.ndone  = 2'(nd);
        return v;
    endfunction

    function automatic logic [DUTY_W-1:0] get_duty(input int unsigned ch);
        return duty[ch*DUTY_W +: DUTY_W];
    endfunction

    function automatic logic [NUM_CH*DUTY_W-1:0] model_bus();
        logic [NUM_CH*DUTY_W-1:0] b;
        for (int i = 0; i < NUM_CH; i++) b[i*DUTY_W +: DUTY_W] = m_duty[i];
        return b;
    endfunction

    // Drive one command and hold it until accepted; returns 1 ns after the
    // accepting posedge.
    task automatic send_cmd(input int unsigned ch, input logic [DUTY_W-1:0] t,
                            input logic [DUTY_W-1:0] s);
        int unsigned n;
        cmd_ch     = CH_W'(ch);
        cmd_target = t;
        cmd_step   = s;
        cmd_valid  = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            test_cnt++;
            fail_cnt++;
            $display("FAIL cmd_accept_timeout: ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for the next scan to start (ready falls) and finish (ready rises).
    task automatic wait_scan();
        int unsigned n;
        n = 0;
        while (cmd_ready === 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        while (cmd_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) begin
            test_cnt++;
            fail_cnt++;
            $display("FAIL scan_timeout: no complete scan within %0d cycles, ready=%b", BOUND, cmd_ready);
        end
    endtask

    initial begin
        vec_t        cv;
        sb_t         e;
        int unsigned dsnap;
        int unsigned nlow;
        logic [DUTY_W-1:0] last;

        // ch, target, step, scans, expected duty per scan, done pulses
        vecs[0] = mk(1, 100,     30,     4, 30,     60,     90, 100, 1);
        vecs[1] = mk(0, 100,     0,      1, 100,    0,      0,  0,   0);
        vecs[2] = mk(0, 10,      40,     3, 60,     20,     10, 0,   1);
        vecs[3] = mk(0, 500,     0,      1, 500,    0,      0,  0,   0);
        vecs[4] = mk(2, 'hFFFF,  'h8000, 2, 'h8000, 'hFFFF, 0,  0,   1);
        vecs[5] = mk(3, 7,       100,    1, 7,      0,      0,  0,   1);
        vecs[6] = mk(2, 0,       'hFFFF, 1, 0,      0,      0,  0,   1);
        vecs[7] = mk(4, 3,       1,      3, 1,      2,      3,  0,   1);

        for (int i = 0; i < NUM_CH; i++) m_duty[i] = '0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_ch     = '0;
        cmd_target = '0;
        cmd_step   = '0;
`ifdef PWM_RAMP_ESTOP_EN
        estop      = 1'b0;
`endif

        // Reset release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_duty", duty, 0);
        check("rst_at_target", at_target, {NUM_CH{1'b1}});
        check("rst_done", done, 0);
        check("rst_cmd_err", cmd_err, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1);
        @(negedge clk);
        check("ready_after_rst_2", cmd_ready, 1);
        check("duty_after_rst", duty, 0);

        // Table-driven ramps through a scoreboard queue
        for (int v = 0; v < 8; v++) begin
            cv = vecs[v];
            @(posedge clk);
            #1;
            dsnap = done_cnt[cv.ch];
            send_cmd(cv.ch, cv.target, cv.step);
            for (int k = 0; k < int'(cv.nscan); k++) begin
                e.ch   = cv.ch;
                e.duty = cv.exp[k];
                sb_q.push_back(e);
            end
            if (cv.step == '0) begin
                check("jump_duty", get_duty(cv.ch), cv.target);
                check("jump_at_target", at_target[cv.ch], 1);
            end
            for (int k = 0; k < int'(cv.nscan); k++) begin
                wait_scan();
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("v%0d_scan%0d_duty", v, k), get_duty(e.ch), e.duty);
                end
            end
            repeat (2) @(posedge clk);
            #1;
            m_duty[cv.ch] = cv.exp[cv.nscan - 1];
            check($sformatf("v%0d_done_pulses", v), done_cnt[cv.ch] - dsnap, cv.ndone);
            check($sformatf("v%0d_at_target", v), at_target[cv.ch], 1);
            check($sformatf("v%0d_all_duty", v), duty, model_bus());
        end

        // Tick and handshake in the same cycle: the scan uses the new target.
        wait_scan();
        repeat (4) @(negedge clk);
        cmd_ch     = 3'd0;
        cmd_target = 16'd505;
        cmd_step   = 16'd5;
        cmd_valid  = 1'b1;
        check("collide_ready_on_tick", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("collide_scan_started", cmd_ready, 0);
        wait_scan();
        m_duty[0] = 16'd505;
        check("collide_new_target_used", get_duty(0), 16'd505);

        // Command held across a scan: ready low for exactly NUM_CH cycles.
        nlow = 0;
        while (cmd_ready === 1'b1 && nlow < BOUND) begin
            @(negedge clk);
            nlow++;
        end
        cmd_ch     = 3'd1;
        cmd_target = 16'd80;
        cmd_step   = 16'd20;
        cmd_valid  = 1'b1;
        nlow = 0;
        while (cmd_ready !== 1'b1 && nlow < BOUND) begin
            nlow++;
            @(negedge clk);
        end
        check("held_ready_low_cycles", nlow, NUM_CH);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("held_accepted_target", at_target[1], 0);
        wait_scan();
        m_duty[1] = 16'd80;
        check("held_ramp_duty", get_duty(1), 16'd80);

        // Invalid channel: error pulse, nothing changes.
        @(posedge clk);
        #1;
        send_cmd(5, 16'h1234, 16'h0000);
        check("bad_ch_err_pulse", cmd_err, 1);
        @(posedge clk);
        #1;
        check("bad_ch_err_clears", cmd_err, 0);
        check("bad_ch_duty_unchanged", duty, model_bus());
        check("bad_ch_at_target", at_target, {NUM_CH{1'b1}});

        // Reset while the scan is on channel 2.
        dsnap = 0;
        while (cmd_ready === 1'b1 && dsnap < BOUND) begin
            @(negedge clk);
            dsnap++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midscan_rst_duty", duty, 0);
        check("midscan_rst_ready", cmd_ready, 0);
        check("midscan_rst_at_target", at_target, {NUM_CH{1'b1}});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midscan_rst_release_ready", cmd_ready, 1);
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = '0;

`ifdef PWM_RAMP_ESTOP_EN
        // Emergency stop during a ramp.
        send_cmd(1, 16'd1000, 16'd10);
        wait_scan();
        last = get_duty(1);
        check("estop_pre_ramp", last, 16'd10);
        estop = 1'b1;
        @(posedge clk);
        #1;
        check("estop_duty_cleared", duty, 0);
        check("estop_ready_low", cmd_ready, 0);
        check("estop_at_target", at_target, {NUM_CH{1'b1}});
        nlow = 0;
        repeat (12) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || done !== '0 || duty !== '0) nlow++;
        end
        check("estop_hold_violations", nlow, 0);
        estop = 1'b0;
        #1;
        check("estop_release_ready", cmd_ready, 1);
        wait_scan();
        check("estop_stays_cleared", duty, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
